// File: rtl/target_rxtx_arbiter.sv
// Round-robin arbiter sharing the target's SDA RX/TX datapath among engine, DDR-NT and CCC.
// One grant at a time, with a watchdog and EXIT/RESTART abort.
module target_rxtx_arbiter #(
  parameter int TMO_W   = 8,
  parameter int TMO_CYC = 200
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  input  logic [2:0]  i_req,
  input  logic [2:0]  i_req_dir,
  input  logic [11:0] i_req_mode,
  input  logic        i_rx_done,
  input  logic        i_tx_done,
  input  logic        i_exitdet_EXIT,
  input  logic        i_rstdet_RESTART,
  output logic [2:0]  o_gnt,
  output logic [2:0]  o_done,
  output logic        o_rx_en,
  output logic [3:0]  o_rx_mode,
  output logic        o_tx_en,
  output logic [3:0]  o_tx_mode,
  output logic [1:0]  o_muxes,
  output logic        o_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_e;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  state_e           state_q;
  logic [1:0]       rr_ptr_q;
  logic [1:0]       idx_q;
  logic             dir_q;
  logic [TMO_W-1:0] cnt_q;
  logic [2:0]       gnt_q;
  logic [2:0]       done_q;
  logic             rx_en_q;
  logic [3:0]       rx_mode_q;
  logic             tx_en_q;
  logic [3:0]       tx_mode_q;
  logic [1:0]       muxes_q;
  logic             timeout_q;

  logic [1:0] win_idx;
  logic       win_dir;
  logic [3:0] win_mode;
  logic       act_done;
  logic       req_held;

  function automatic logic [1:0] next_idx(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // First pending requester starting at the round-robin pointer.
  function automatic logic [1:0] pick_winner(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] c;
    logic [1:0] w;
    logic       found;
    c     = ptr;
    w     = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!found && req[c]) begin
        w     = c;
        found = 1'b1;
      end
      c = next_idx(c);
    end
    return w;
  endfunction

  assign win_idx  = pick_winner(i_req, rr_ptr_q);
  assign win_dir  = i_req_dir[win_idx];
  assign win_mode = i_req_mode[{win_idx, 2'b00} +: 4];
  assign act_done = dir_q ? i_tx_done : i_rx_done;
  assign req_held = i_req[idx_q];

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= 2'd0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rx_en_q   <= 1'b0;
      rx_mode_q <= '0;
      tx_en_q   <= 1'b0;
      tx_mode_q <= '0;
      muxes_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      done_q    <= '0;
      timeout_q <= 1'b0;
      if (i_exitdet_EXIT || i_rstdet_RESTART) begin
        state_q   <= S_IDLE;
        cnt_q     <= '0;
        gnt_q     <= '0;
        rx_en_q   <= 1'b0;
        rx_mode_q <= '0;
        tx_en_q   <= 1'b0;
        tx_mode_q <= '0;
        muxes_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (|i_req) begin
              state_q   <= S_BUSY;
              cnt_q     <= '0;
              idx_q     <= win_idx;
              dir_q     <= win_dir;
              gnt_q     <= 3'b001 << win_idx;
              muxes_q   <= win_idx;
              rx_en_q   <= ~win_dir;
              rx_mode_q <= win_dir ? 4'd0 : win_mode;
              tx_en_q   <= win_dir;
              tx_mode_q <= win_dir ? win_mode : 4'd0;
            end
          end
          S_BUSY: begin
            cnt_q <= cnt_q + TMO_W'(1);
            // Done beats requester drop, which beats the watchdog.
            if (act_done || !req_held || (cnt_q == TMO_LAST)) begin
              state_q   <= S_RELEASE;
              rr_ptr_q  <= next_idx(idx_q);
              gnt_q     <= '0;
              rx_en_q   <= 1'b0;
              rx_mode_q <= '0;
              tx_en_q   <= 1'b0;
              tx_mode_q <= '0;
              muxes_q   <= '0;
              if (act_done) begin
                done_q <= 3'b001 << idx_q;
              end else if (req_held) begin
                timeout_q <= 1'b1;
              end
            end
          end
          S_RELEASE: begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_gnt     = gnt_q;
  assign o_done    = done_q;
  assign o_rx_en   = rx_en_q;
  assign o_rx_mode = rx_mode_q;
  assign o_tx_en   = tx_en_q;
  assign o_tx_mode = tx_mode_q;
  assign o_muxes   = muxes_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_target_rxtx_arbiter.sv
// Directed scenarios plus randomized traffic for target_rxtx_arbiter, checked cycle by cycle
// against a grant-ownership model of the arbitration rules.
module tb_target_rxtx_arbiter;

  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  req_dir;
  logic [11:0] req_mode;
  logic        rx_done;
  logic        tx_done;
  logic        ext;
  logic        rsr;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic        rx_en;
  logic [3:0]  rx_mode;
  logic        tx_en;
  logic [3:0]  tx_mode;
  logic [1:0]  muxes;
  logic        tmo;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: who owns the datapath, for how long, and whether a release gap is pending.
  int         m_owner = -1;
  int         m_age   = 0;
  int         m_hold  = 0;
  int         m_ptr   = 0;
  logic       m_dir   = 1'b0;
  logic [3:0] m_mode  = 4'd0;
  logic [2:0] m_done  = 3'd0;
  logic       m_to    = 1'b0;
  int         grant_log[$];

  target_rxtx_arbiter #(.TMO_W(8), .TMO_CYC(TMO)) dut (
    .i_sys_clk        (clk),
    .i_sys_rst        (rst),
    .i_req            (req),
    .i_req_dir        (req_dir),
    .i_req_mode       (req_mode),
    .i_rx_done        (rx_done),
    .i_tx_done        (tx_done),
    .i_exitdet_EXIT   (ext),
    .i_rstdet_RESTART (rsr),
    .o_gnt            (gnt),
    .o_done           (done),
    .o_rx_en          (rx_en),
    .o_rx_mode        (rx_mode),
    .o_tx_en          (tx_en),
    .o_tx_mode        (tx_mode),
    .o_muxes          (muxes),
    .o_timeout        (tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL sim_timeout observed=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_tick();
    bit rel;
    bit found;
    rel    = 1'b0;
    m_done = 3'd0;
    m_to   = 1'b0;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_hold = 0;
    end else if (ext || rsr) begin
      m_owner = -1; m_hold = 0;
    end else if (m_owner >= 0) begin
      if (m_dir ? tx_done : rx_done) begin
        m_done = 3'(1 << m_owner); rel = 1'b1;
      end else if (!req[m_owner]) begin
        rel = 1'b1;
      end else if (m_age == TMO) begin
        m_to = 1'b1; rel = 1'b1;
      end else begin
        m_age++;
      end
      if (rel) begin
        m_ptr   = (m_owner + 1) % 3;
        m_owner = -1;
        m_hold  = 1;
      end
    end else if (m_hold != 0) begin
      m_hold = 0;
    end else if (req != 3'd0) begin
      found = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (!found && req[(m_ptr + k) % 3]) begin
          found   = 1'b1;
          m_owner = (m_ptr + k) % 3;
        end
      end
      m_dir  = req_dir[m_owner];
      m_mode = req_mode[4*m_owner +: 4];
      m_age  = 1;
      grant_log.push_back(m_owner);
    end
  endtask

  task automatic check_outputs();
    logic       own;
    logic [2:0] e_gnt;
    own   = (m_owner >= 0);
    e_gnt = own ? 3'(1 << m_owner) : 3'd0;
    chk("gnt",     32'(gnt),     32'(e_gnt));
    chk("muxes",   32'(muxes),   own ? 32'(m_owner) : 32'd0);
    chk("rx_en",   32'(rx_en),   32'(own && !m_dir));
    chk("rx_mode", 32'(rx_mode), (own && !m_dir) ? 32'(m_mode) : 32'd0);
    chk("tx_en",   32'(tx_en),   32'(own && m_dir));
    chk("tx_mode", 32'(tx_mode), (own && m_dir) ? 32'(m_mode) : 32'd0);
    chk("done",    32'(done),    32'(m_done));
    chk("timeout", 32'(tmo),     32'(m_to));
    chk("inv_onehot", 32'($onehot0(gnt)), 32'd1);
    chk("inv_en",     32'(rx_en && tx_en), 32'd0);
    chk("inv_mux0",   32'((gnt == 3'd0) && (muxes != 2'd0)), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    check_outputs();
  endtask

  task automatic wait_gnt(input string tag);
    int n;
    n = 0;
    while (gnt == 3'd0 && n < 10) begin
      step();
      n++;
    end
    chk(tag, 32'(gnt != 3'd0), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; req = '0; req_dir = '0; req_mode = '0;
    rx_done = 1'b0; tx_done = 1'b0; ext = 1'b0; rsr = 1'b0;

    // Reset state
    do_reset();
    chk("reset_gnt", 32'(gnt), 32'd0);
    step();

    // T1: single RX grant to req1, done on BUSY cycle 5
    req = 3'b010; req_mode = 12'h020;
    step();
    chk("t1_gnt",   32'(gnt),     32'h2);
    chk("t1_muxes", 32'(muxes),   32'h1);
    chk("t1_rmode", 32'(rx_mode), 32'h2);
    repeat (4) step();
    rx_done = 1'b1;
    step();
    rx_done = 1'b0; req = 3'b000;
    chk("t1_done", 32'(done), 32'h2);
    step();
    chk("t1_done_pulse", 32'(done), 32'h0);
    repeat (2) step();

    // T2: round robin with all three held
    do_reset();
    grant_log.delete();
    req = 3'b111; req_dir = 3'b000; req_mode = 12'h321;
    for (int g = 0; g < 4; g++) begin
      wait_gnt("t2_wait");
      step();
      rx_done = 1'b1;
      step();
      rx_done = 1'b0;
    end
    req = 3'b000;
    chk("t2_len", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      chk("t2_g0", 32'(grant_log[0]), 32'd0);
      chk("t2_g1", 32'(grant_log[1]), 32'd1);
      chk("t2_g2", 32'(grant_log[2]), 32'd2);
      chk("t2_g3", 32'(grant_log[3]), 32'd0);
    end
    repeat (3) step();

    // T3: TX grant to req2; RX done is ignored
    req = 3'b100; req_dir = 3'b100; req_mode = 12'h500;
    step();
    chk("t3_tx_en", 32'(tx_en),   32'h1);
    chk("t3_tmode", 32'(tx_mode), 32'h5);
    chk("t3_muxes", 32'(muxes),   32'h2);
    req_mode = 12'hA00;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    chk("t3_rx_ign", 32'(done), 32'h0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0; req = 3'b000; req_dir = 3'b000;
    chk("t3_done", 32'(done), 32'h4);
    repeat (2) step();

    // T4: watchdog on req0
    req = 3'b001; req_mode = 12'h007;
    wait_gnt("t4_wait");
    n = 0;
    while (tmo == 1'b0 && n < 300) begin
      step();
      n++;
    end
    chk("t4_cycles", 32'(n), 32'(TMO));
    chk("t4_gnt",    32'(gnt),  32'h0);
    chk("t4_done",   32'(done), 32'h0);
    req = 3'b000;
    repeat (2) step();

    // T5: EXIT then RESTART alongside rx_done
    req = 3'b010; req_mode = 12'h030;
    wait_gnt("t5_wait_a");
    step();
    ext = 1'b1; rx_done = 1'b1;
    step();
    ext = 1'b0; rx_done = 1'b0;
    chk("t5_exit_gnt",  32'(gnt),  32'h0);
    chk("t5_exit_done", 32'(done), 32'h0);
    wait_gnt("t5_wait_b");
    step();
    rsr = 1'b1; rx_done = 1'b1;
    step();
    rsr = 1'b0; rx_done = 1'b0;
    chk("t5_rst_gnt",  32'(gnt),  32'h0);
    chk("t5_rst_done", 32'(done), 32'h0);
    req = 3'b000;
    repeat (3) step();

    // T6: reset mid-grant, then req0 wins
    req = 3'b111;
    wait_gnt("t6_wait");
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_gnt", 32'(gnt), 32'h0);
    step();
    chk("t6_first", 32'(gnt), 32'h1);
    req = 3'b000;
    repeat (3) step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < 3; r++) begin
        if ($urandom_range(7) == 0) req[r] = ~req[r];
      end
      req_dir  = 3'($urandom);
      req_mode = 12'($urandom);
      rx_done  = ($urandom_range(3) == 0);
      tx_done  = ($urandom_range(3) == 0);
      ext      = ($urandom_range(63) == 0);
      rsr      = ($urandom_range(63) == 0);
      rst      = ($urandom_range(127) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
